// File: rtl/bpsk_ask_demodulator.sv
// bpsk_ask_demodulator: square-wave correlation demodulator for 64-sample-per-bit BPSK/ASK
// Ports: clk/rst (sync, active-high); sample_in/sample_valid carry the offset-sine samples;
// mode selects BPSK(0)/ASK(1) per symbol; sync restarts alignment; bit_out/corr_out are
// updated with a one-cycle bit_valid strobe at each completed symbol.
module bpsk_ask_demodulator #(
  parameter int BPSK_OFFSET = 1000,
  parameter int ASK_OFFSET = 10000,
  parameter int ASK_THRESH = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        mode,
  input  logic        sync,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [23:0] corr_out
);
  localparam logic signed [23:0] THR = 24'(ASK_THRESH);
  logic [5:0] phase_q, phase_d, ph;
  logic signed [23:0] acc_q, acc_d, corr_q, corr_d, term, sum;
  logic signed [16:0] off, diff;
  logic mode_lat_q, mode_lat_d, eff_mode, last;
  logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  // sync makes this cycle behave as phase 0 of a fresh symbol with an empty accumulator
  always_comb begin
    ph = sync ? 6'd0 : phase_q;
    eff_mode = (ph == 6'd0) ? mode : mode_lat_q;
    off = eff_mode ? 17'(ASK_OFFSET) : 17'(BPSK_OFFSET);
    diff = $signed({1'b0, sample_in}) - off;
    term = ph[5] ? -{{7{diff[16]}}, diff} : {{7{diff[16]}}, diff};
    sum = (sync ? 24'sd0 : acc_q) + term;
    last = sample_valid && ph == 6'd63;
    phase_d = sample_valid ? ph + 6'd1 : ph;
    acc_d = last ? 24'sd0 : sample_valid ? sum : sync ? 24'sd0 : acc_q;
    mode_lat_d = sample_valid ? eff_mode : mode_lat_q;
    bit_valid_d = last;
    corr_d = last ? sum : corr_q;
    bit_out_d = last ? (eff_mode ? sum > THR : sum > 24'sd0) : bit_out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      acc_q <= '0;
      mode_lat_q <= 1'b0;
      corr_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q <= acc_d;
      mode_lat_q <= mode_lat_d;
      corr_q <= corr_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end
  assign bit_out = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign corr_out = corr_q;
endmodule

// File: tb/tb_bpsk_ask_demodulator.sv
// tb_bpsk_ask_demodulator: directed + randomized check against a symbol-level correlation model
module tb_bpsk_ask_demodulator;
  logic clk = 1'b0;
  logic rst, sample_valid, mode, sync, bit_out, bit_valid;
  logic [15:0] sample_in;
  logic [23:0] corr_out;
  int n_cmp = 0, n_bad = 0;
  int tbl[64];
  int samp[64];
  int idx = 0;
  bit msym = 0;
  int e_corr = 0;
  bit e_bit = 0, e_valid = 0;

  bpsk_ask_demodulator dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .mode(mode), .sync(sync), .bit_out(bit_out), .bit_valid(bit_valid), .corr_out(corr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock with the given inputs; the model collects whole symbols and correlates them at once.
  task automatic step(input int s, input bit v, input bit sy, input bit m, input bit r);
    int off, c;
    sample_in = 16'(s);
    sample_valid = v;
    sync = sy;
    mode = m;
    rst = r;
    @(posedge clk);
    #1;
    e_valid = 0;
    if (r) begin
      idx = 0;
      e_corr = 0;
      e_bit = 0;
    end else begin
      if (sy) idx = 0;
      if (v) begin
        if (idx == 0) msym = m;
        samp[idx] = s;
        idx++;
        if (idx == 64) begin
          off = msym ? 10000 : 1000;
          c = 0;
          for (int i = 0; i < 64; i++) c += (i < 32 ? 1 : -1) * (samp[i] - off);
          e_corr = c;
          e_bit = msym ? (c > 200000) : (c > 0);
          e_valid = 1;
          idx = 0;
        end
      end
    end
    chk("bit_valid", int'(bit_valid), int'(e_valid));
    chk("bit_out", int'(bit_out), int'(e_bit));
    chk("corr_out", int'($signed(corr_out)), e_corr);
  endtask

  function automatic int val(input int kind, input int i);
    case (kind)
      0: return tbl[i];
      1: return tbl[(i + 32) % 64];
      2: return 10 * tbl[i];
      3: return 10000;
      4: return i < 32 ? 65535 : 0;
      default: return 1000;
    endcase
  endfunction

  task automatic sym(input int kind, input bit m, input int gap);
    for (int i = 0; i < 64; i++) begin
      step(val(kind, i), 1, 0, m, 0);
      for (int g = 0; g < gap; g++) step($urandom_range(0, 65535), 0, 0, m, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = int'(1000.0 + 1000.0 * $sin(6.283185307179586 * i / 64.0));
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    // BPSK: table then pi-shifted table
    sym(0, 0, 0);
    chk("bpsk1_corr_sign", int'($signed(corr_out) > 40000), 1);
    sym(1, 0, 0);
    // ASK: scaled table then constant level
    sym(2, 1, 0);
    sym(3, 1, 0);
    // mode toggled mid-symbol must not affect this symbol
    for (int i = 0; i < 64; i++) step(tbl[i], 1, 0, i >= 30, 0);
    sym(1, 0, 0);
    // gaps of 3 cycles between samples
    sym(0, 0, 3);
    // sync realignment, then sync on the 64th sample
    for (int i = 0; i < 20; i++) step(tbl[(i * 7) % 64], 1, 0, 0, 0);
    step(tbl[0], 1, 1, 0, 0);
    for (int i = 1; i < 64; i++) step(tbl[i], 1, 0, 0, 0);
    for (int i = 0; i < 63; i++) step(tbl[i], 1, 0, 0, 0);
    step(tbl[63], 1, 1, 0, 0);
    for (int i = 1; i < 64; i++) step(tbl[i], 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // extremes
    sym(4, 0, 0);
    sym(5, 0, 0);
    // reset mid-symbol and on the 64th sample
    for (int i = 0; i < 40; i++) step(tbl[i], 1, 0, 0, 0);
    step(tbl[40], 1, 0, 0, 1);
    for (int i = 0; i < 63; i++) step(tbl[i], 1, 0, 0, 0);
    step(tbl[63], 1, 0, 0, 1);
    sym(0, 0, 0);
    // randomized traffic
    begin
      bit m = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 49) == 0) m = ~m;
        step($urandom_range(0, 65535), $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, m,
             $urandom_range(0, 799) == 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
